// File: rtl/matmul_ctrl.sv
// Sequencing controller that reads a job descriptor from data_mem, computes
// C = A x B with one MAC per operand pair, and writes 16-bit C elements back.
module matmul_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_w_addr,
  output logic [2*DATA_WIDTH-1:0] mem_w_data,
  output logic [ADDR_WIDTH-1:0]   mem_r_addr,
  input  logic [DATA_WIDTH-1:0]   mem_r_data
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CFG_ISS = 4'd1;
  localparam logic [3:0] S_CFG_CAP = 4'd2;
  localparam logic [3:0] S_CLR     = 4'd3;
  localparam logic [3:0] S_A_ISS   = 4'd4;
  localparam logic [3:0] S_A_CAP   = 4'd5;
  localparam logic [3:0] S_B_ISS   = 4'd6;
  localparam logic [3:0] S_B_CAP   = 4'd7;
  localparam logic [3:0] S_WR      = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;

  logic [3:0]              state;
  logic [2:0]              cfg_idx;
  logic [ADDR_WIDTH-1:0]   m, n, l, a_base, c_base;
  logic [ADDR_WIDTH-1:0]   i, j, k;
  logic [DATA_WIDTH-1:0]   a_reg;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] product;
  logic [ADDR_WIDTH-1:0]   cfg_addr, a_addr, b_base, b_addr, c_addr;
  logic [ADDR_WIDTH-1:0]   cap_val;

  // Address generation; all arithmetic wraps at ADDR_WIDTH, elements use a 2-byte stride.
  assign b_base  = a_base + ((m * n) << 1);
  assign a_addr  = a_base + ((i * n + k) << 1);
  assign b_addr  = b_base + ((k * l + j) << 1);
  assign c_addr  = c_base + ((i * l + j) << 1);
  assign product = (2*DATA_WIDTH)'(a_reg) * (2*DATA_WIDTH)'(mem_r_data);
  assign cap_val = ADDR_WIDTH'(mem_r_data);

  always_comb begin
    cfg_addr = '0;
    case (cfg_idx)
      3'd0:    cfg_addr = ADDR_WIDTH'(0);
      3'd1:    cfg_addr = ADDR_WIDTH'(2);
      3'd2:    cfg_addr = ADDR_WIDTH'(4);
      3'd3:    cfg_addr = ADDR_WIDTH'(12);
      3'd4:    cfg_addr = ADDR_WIDTH'(14);
      default: cfg_addr = '0;
    endcase
  end

  // Read address is held across both the issue and capture cycle of each access.
  always_comb begin
    mem_r_addr = '0;
    case (state)
      S_CFG_ISS, S_CFG_CAP: mem_r_addr = cfg_addr;
      S_A_ISS, S_A_CAP:     mem_r_addr = a_addr;
      S_B_ISS, S_B_CAP:     mem_r_addr = b_addr;
      default:              mem_r_addr = '0;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign mem_we     = (state == S_WR);
  assign mem_w_addr = (state == S_WR) ? c_addr : '0;
  assign mem_w_data = (state == S_WR) ? acc : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cfg_idx <= '0;
      m       <= '0;
      n       <= '0;
      l       <= '0;
      a_base  <= '0;
      c_base  <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      a_reg   <= '0;
      acc     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_idx <= '0;
            state   <= S_CFG_ISS;
          end
        end
        S_CFG_ISS: state <= S_CFG_CAP;
        S_CFG_CAP: begin
          case (cfg_idx)
            3'd0:    m      <= cap_val;
            3'd1:    n      <= cap_val;
            3'd2:    l      <= cap_val;
            3'd3:    a_base <= cap_val;
            default: c_base <= cap_val;
          endcase
          if (cfg_idx == 3'd4) begin
            i <= '0;
            j <= '0;
            k <= '0;
            // m, n and l were captured in earlier passes, so they are valid here.
            state <= (m == '0 || n == '0 || l == '0) ? S_DONE : S_CLR;
          end else begin
            cfg_idx <= cfg_idx + 3'd1;
            state   <= S_CFG_ISS;
          end
        end
        S_CLR: begin
          acc   <= '0;
          state <= S_A_ISS;
        end
        S_A_ISS: state <= S_A_CAP;
        S_A_CAP: begin
          a_reg <= mem_r_data;
          state <= S_B_ISS;
        end
        S_B_ISS: state <= S_B_CAP;
        S_B_CAP: begin
          acc <= acc + product;
          if (k != n - 1'b1) begin
            k     <= k + 1'b1;
            state <= S_A_ISS;
          end else begin
            k     <= '0;
            state <= S_WR;
          end
        end
        S_WR: begin
          if (j != l - 1'b1) begin
            j     <= j + 1'b1;
            state <= S_CLR;
          end else if (i != m - 1'b1) begin
            j     <= '0;
            i     <= i + 1'b1;
            state <= S_CLR;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl with a behavioural data_mem and a write scoreboard
// holding the expected C writes in order.
module tb_matmul_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, mem_we;
  logic [7:0]  mem_w_addr, mem_r_addr;
  logic [15:0] mem_w_data;
  logic [7:0]  mem_r_data;

  logic [7:0]  mem [0:255];

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  we_count = 0;

  matmul_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_we     (mem_we),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data)
  );

  always #5 clk = ~clk;

  // Single-port memory: registered read, 16-bit write split over two bytes.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_w_addr]        <= mem_w_data[7:0];
      mem[mem_w_addr + 8'd1] <= mem_w_data[15:8];
    end else begin
      mem_r_data <= mem[mem_r_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every write is popped against the scoreboard head.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && mem_we) begin
      we_count++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("[TB] FAIL unexpected_write: observed addr %0d data %0d expected no write",
               mem_w_addr, mem_w_data);
      end else begin
        e = sb.pop_front();
        checkOutput("w_addr", 32'(mem_w_addr), 32'(e.addr));
        checkOutput("w_data", 32'(mem_w_data), 32'(e.data));
      end
    end
  end

  task automatic clearMem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  task automatic loadDesc(input logic [7:0] m, input logic [7:0] n, input logic [7:0] l,
                          input logic [7:0] ab, input logic [7:0] cb);
    mem[0]  = m;
    mem[2]  = n;
    mem[4]  = l;
    mem[12] = ab;
    mem[14] = cb;
  endtask

  // Fills count elements from ab; val==0 means sequential values 1,2,3...; odd bytes get junk.
  task automatic fillOperands(input logic [7:0] ab, input int count, input logic [7:0] val);
    logic [7:0] ad;
    for (int e = 0; e < count; e++) begin
      ad          = ab + 8'(2 * e);
      mem[ad]     = (val == 8'd0) ? 8'(e + 1) : val;
      mem[ad + 1] = 8'hEE;
    end
  endtask

  task automatic pushWrite(input logic [7:0] addr, input logic [15:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic loadDefault();
    clearMem();
    loadDesc(8'd2, 8'd3, 8'd2, 8'd16, 8'd150);
    fillOperands(8'd16, 12, 8'd0);
  endtask

  task automatic pushDefault();
    pushWrite(8'd150, 16'd58);
    pushWrite(8'd152, 16'd64);
    pushWrite(8'd154, 16'd139);
    pushWrite(8'd156, 16'd154);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},   32'(busy), 0);
    checkOutput({tag, "_done"},   32'(done), 0);
    checkOutput({tag, "_we"},     32'(mem_we), 0);
    checkOutput({tag, "_waddr"},  32'(mem_w_addr), 0);
    checkOutput({tag, "_wdata"},  32'(mem_w_data), 0);
    checkOutput({tag, "_raddr"},  32'(mem_r_addr), 0);
  endtask

  // Runs one job; cycle 1 is the cycle after the edge that samples start.
  task automatic applyStimulus(input string tag, input int repulse_at, input int reset_at,
                               input int exp_done, input int exp_writes);
    int cyc;
    int done_cyc;
    we_count = 0;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (cyc = 1; cyc <= 400; cyc++) begin
      if (cyc == repulse_at) start = 1'b1;
      if (cyc == repulse_at + 1) start = 1'b0;
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        checkResetOutputs({tag, "_rst"});
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        checkOutput({tag, "_rst_idle"}, 32'(busy), 0);
        return;
      end
      checkOutput({tag, "_busy"}, 32'(busy), 1);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    @(posedge clk);
    #1;
    checkOutput({tag, "_busy_after"}, 32'(busy), 0);
    checkOutput({tag, "_done_after"}, 32'(done), 0);
    checkOutput({tag, "_we_count"}, 32'(we_count), 32'(exp_writes));
    checkOutput({tag, "_sb_left"}, 32'(sb.size()), 0);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0;
    clearMem();
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] default job");
    loadDefault();
    pushDefault();
    applyStimulus("default", 0, 0, 67, 4);

    $display("[TB] accumulator wrap");
    clearMem();
    loadDesc(8'd1, 8'd3, 8'd1, 8'd16, 8'd100);
    fillOperands(8'd16, 6, 8'd255);
    pushWrite(8'd100, 16'd64003);
    applyStimulus("overflow", 0, 0, 25, 1);

    $display("[TB] zero dimension");
    clearMem();
    loadDesc(8'd2, 8'd0, 8'd2, 8'd16, 8'd150);
    applyStimulus("zero_n", 0, 0, 11, 0);

    $display("[TB] start while busy");
    loadDefault();
    pushDefault();
    applyStimulus("repulse", 20, 0, 67, 4);

    $display("[TB] reset mid-job then rerun");
    loadDefault();
    pushDefault();
    applyStimulus("midreset", 0, 30, 0, 0);
    pushDefault();
    applyStimulus("rerun", 0, 0, 67, 4);

    $display("[TB] back-to-back jobs");
    loadDefault();
    pushDefault();
    pushDefault();
    we_count = 0;
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 400 && dones < 2; c++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
      if (dones == 1 && busy && !done) start = 1'b0;
    end
    start = 1'b0;
    checkOutput("b2b_dones", 32'(dones), 2);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("b2b_busy_after", 32'(busy), 0);
    checkOutput("b2b_we_count", 32'(we_count), 8);
    checkOutput("b2b_sb_left", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
